// File: rtl/global_defs_pkg.sv
// Shared definitions for the trace parser / request queue / DRAM scheduler path.
// Holds the parsed op encoding, address width and request-queue types.
package global_defs;

    localparam int ADDRESS_WIDTH       = 32;
    localparam int QUEUE_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        REFRESH = 2'd3
    } parsed_op_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } queue_state_t;

    typedef struct packed {
        parsed_op_t                 opcode;
        logic [ADDRESS_WIDTH-1:0]   address;
    } queue_entry_t;

endpackage

// File: rtl/queue_entry_ram.sv
// Entry storage for request_queue: one write port, one pointer-indexed read port.
// With REQ_AGE_EN defined, each entry also carries a saturating age counter.
module queue_entry_ram
    import global_defs::*;
#(
    parameter int DEPTH     = QUEUE_DEPTH_DEFAULT,
`ifdef REQ_AGE_EN
    parameter int AGE_WIDTH = 8,
`endif
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_W-1:0]     wr_ptr,
    input  queue_entry_t         wr_entry,
    input  logic [PTR_W-1:0]     rd_ptr,
    output queue_entry_t         rd_entry
`ifdef REQ_AGE_EN
   ,output logic [AGE_WIDTH-1:0] rd_age
`endif
);

    queue_entry_t entries [DEPTH];

    // NOTE: storage is deliberately not reset; the control logic masks the
    // head outputs whenever the queue is empty, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_ptr] <= wr_entry;
        end
    end

    assign rd_entry = entries[rd_ptr];

`ifdef REQ_AGE_EN
    logic [AGE_WIDTH-1:0] ages [DEPTH];

    // Free-running on every slot; a slot's age only matters between its
    // enqueue (which zeroes it) and its dequeue.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_ptr == PTR_W'(i))) begin
                ages[i] <= '0;
            end else if (ages[i] != '1) begin
                ages[i] <= ages[i] + 1'b1;
            end
        end
    end

    assign rd_age = ages[rd_ptr];
`endif

endmodule

// File: rtl/request_queue.sv
// Bounded in-order request queue between the trace parser and the DRAM scheduler.
// Optional feature: define REQ_AGE_EN to add per-entry age tracking and the deq_age port.
module request_queue
    import global_defs::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int AGE_WIDTH   = 8,
    localparam int PTR_W      = $clog2(QUEUE_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_ready_s,
    input  parsed_op_t               opcode,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic                     queue_full,
    output logic                     queue_empty,
    output logic [CNT_W-1:0]         occupancy,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output parsed_op_t               deq_opcode,
    output logic [ADDRESS_WIDTH-1:0] deq_address,
    output logic                     overflow_err
`ifdef REQ_AGE_EN
   ,output logic [AGE_WIDTH-1:0]     deq_age
`endif
);

    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count, count_next;
    queue_state_t     state, state_next;
    queue_entry_t     head;
    logic             strobe_op, enq, deq;

    // Full check uses the pre-edge count, so a strobe while full is dropped
    // even when the scheduler frees a slot in the same cycle.
    assign strobe_op = op_ready_s && (opcode != NOP);
    assign enq       = strobe_op && (count < CNT_W'(QUEUE_DEPTH));
    assign deq       = deq_valid && deq_ready;

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (enq) wptr <= wptr + PTR_W'(1);
            if (deq) rptr <= rptr + PTR_W'(1);
            count <= count_next;
            if (strobe_op && !enq) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:  if (enq) state_next = ACTIVE;
            ACTIVE: begin
                if (count_next == CNT_W'(QUEUE_DEPTH)) state_next = FULL;
                else if (count_next == '0)             state_next = EMPTY;
            end
            FULL:   if (deq) state_next = ACTIVE;
            default: state_next = EMPTY;
        endcase
    end

    queue_entry_t wr_entry;
    assign wr_entry = '{opcode: opcode, address: address};

`ifdef REQ_AGE_EN
    logic [AGE_WIDTH-1:0] head_age;
`endif

    queue_entry_ram #(
        .DEPTH     (QUEUE_DEPTH)
`ifdef REQ_AGE_EN
       ,.AGE_WIDTH (AGE_WIDTH)
`endif
    ) u_ram (
        .clk      (clk),
        .wr_en    (enq),
        .wr_ptr   (wptr),
        .wr_entry (wr_entry),
        .rd_ptr   (rptr),
        .rd_entry (head)
`ifdef REQ_AGE_EN
       ,.rd_age   (head_age)
`endif
    );

    assign queue_full  = (state == FULL);
    assign queue_empty = (state == EMPTY);
    assign occupancy   = count;
    assign deq_valid   = !queue_empty;
    assign deq_opcode  = deq_valid ? head.opcode  : NOP;
    assign deq_address = deq_valid ? head.address : '0;
`ifdef REQ_AGE_EN
    assign deq_age     = deq_valid ? head_age : '0;
`endif

endmodule

// File: tb/tb_request_queue.sv
// Directed self-checking bench for request_queue (depth 16).
// Define REQ_AGE_EN to also exercise age saturation with AGE_WIDTH = 4.
module tb_request_queue;
    import global_defs::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     op_ready_s = 1'b0;
    parsed_op_t               opcode = NOP;
    logic [ADDRESS_WIDTH-1:0] address = '0;
    logic                     queue_full, queue_empty, deq_valid, overflow_err;
    logic [4:0]               occupancy;
    logic                     deq_ready = 1'b0;
    parsed_op_t               deq_opcode;
    logic [ADDRESS_WIDTH-1:0] deq_address;
`ifdef REQ_AGE_EN
    logic [AW-1:0]            deq_age;
`endif

    int pass_count  = 0;
    int check_count = 0;

    request_queue #(.QUEUE_DEPTH(DEPTH), .AGE_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_ready_s   (op_ready_s),
        .opcode       (opcode),
        .address      (address),
        .queue_full   (queue_full),
        .queue_empty  (queue_empty),
        .occupancy    (occupancy),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_opcode   (deq_opcode),
        .deq_address  (deq_address),
        .overflow_err (overflow_err)
`ifdef REQ_AGE_EN
       ,.deq_age      (deq_age)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        op_ready_s = 1'b0;
        opcode     = NOP;
        address    = '0;
        deq_ready  = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input parsed_op_t op, input logic [31:0] addr);
        op_ready_s = 1'b1;
        opcode     = op;
        address    = addr;
        tick();
        op_ready_s = 1'b0;
        opcode     = NOP;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < DEPTH; k++) push(READ, base + 32'(k * 4));
    endtask

    task automatic test_reset();
        do_reset();
        check_count++; if (queue_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", queue_empty); else pass_count++;
        check_count++; if (queue_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", queue_full); else pass_count++;
        check_count++; if (occupancy !== 5'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy); else pass_count++;
        check_count++; if (deq_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", deq_valid); else pass_count++;
        check_count++; if (deq_opcode !== NOP) $display("FAIL reset_opcode got=%0d exp=0", deq_opcode); else pass_count++;
        check_count++; if (deq_address !== 32'h0) $display("FAIL reset_addr got=%h exp=0", deq_address); else pass_count++;
        check_count++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow_err); else pass_count++;
`ifdef REQ_AGE_EN
        check_count++; if (deq_age !== '0) $display("FAIL reset_age got=%0d exp=0", deq_age); else pass_count++;
`endif
        // NOP strobe and deq_ready while empty are both ignored
        deq_ready = 1'b1;
        push(NOP, 32'hFFFF_0000);
        deq_ready = 1'b0;
        check_count++; if (occupancy !== 5'd0 || deq_valid !== 1'b0) $display("FAIL nop_ignored got occ=%0d valid=%b exp occ=0 valid=0", occupancy, deq_valid); else pass_count++;
    endtask

    task automatic test_single();
        do_reset();
        push(READ, 32'h1000);
        check_count++; if (deq_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", deq_valid); else pass_count++;
        check_count++; if (deq_address !== 32'h1000) $display("FAIL single_addr got=%h exp=1000", deq_address); else pass_count++;
        check_count++; if (deq_opcode !== READ) $display("FAIL single_opcode got=%0d exp=%0d", deq_opcode, READ); else pass_count++;
        check_count++; if (occupancy !== 5'd1) $display("FAIL single_occ got=%0d exp=1", occupancy); else pass_count++;
        tick();
        check_count++; if (deq_address !== 32'h1000) $display("FAIL single_hold got=%h exp=1000", deq_address); else pass_count++;
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check_count++; if (queue_empty !== 1'b1 || occupancy !== 5'd0) $display("FAIL single_drain got empty=%b occ=%0d exp empty=1 occ=0", queue_empty, occupancy); else pass_count++;
    endtask

    task automatic test_overflow();
        do_reset();
        fill(32'h4000);
        check_count++; if (queue_full !== 1'b1) $display("FAIL fill_full got=%b exp=1", queue_full); else pass_count++;
        check_count++; if (occupancy !== 5'd16) $display("FAIL fill_occ got=%0d exp=16", occupancy); else pass_count++;
        push(NOP, 32'h0);
        check_count++; if (overflow_err !== 1'b0) $display("FAIL full_nop_ovf got=%b exp=0", overflow_err); else pass_count++;
        push(WRITE, 32'hDEAD);
        check_count++; if (overflow_err !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow_err); else pass_count++;
        check_count++; if (occupancy !== 5'd16) $display("FAIL ovf_occ got=%0d exp=16", occupancy); else pass_count++;
        check_count++; if (deq_address !== 32'h4000) $display("FAIL ovf_head got=%h exp=4000", deq_address); else pass_count++;
    endtask

    task automatic test_full_strobe_deq();
        do_reset();
        fill(32'h4000);
        check_count++; if (overflow_err !== 1'b0) $display("FAIL fsd_pre_ovf got=%b exp=0", overflow_err); else pass_count++;
        deq_ready = 1'b1;
        push(WRITE, 32'hBEEF);
        deq_ready = 1'b0;
        check_count++; if (overflow_err !== 1'b1) $display("FAIL fsd_ovf got=%b exp=1", overflow_err); else pass_count++;
        check_count++; if (occupancy !== 5'd15) $display("FAIL fsd_occ got=%0d exp=15", occupancy); else pass_count++;
        check_count++; if (queue_full !== 1'b0) $display("FAIL fsd_full got=%b exp=0", queue_full); else pass_count++;
        check_count++; if (deq_address !== 32'h4004) $display("FAIL fsd_head got=%h exp=4004", deq_address); else pass_count++;
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check_count++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow_err); else pass_count++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 5; k++) push(READ, 32'h3000 + 32'(k * 4));
        check_count++; if (occupancy !== 5'd5) $display("FAIL sim_pre_occ got=%0d exp=5", occupancy); else pass_count++;
        deq_ready = 1'b1;
        push(WRITE, 32'h3014);
        deq_ready = 1'b0;
        check_count++; if (occupancy !== 5'd5) $display("FAIL sim_occ got=%0d exp=5", occupancy); else pass_count++;
        check_count++; if (deq_address !== 32'h3004) $display("FAIL sim_head got=%h exp=3004", deq_address); else pass_count++;
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          recv = 0;
        int          model = 0;
        logic        strobe;
        logic [31:0] lfsr = 32'hACE1_1357;
        do_reset();
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            strobe     = (sent < 20) && (model < DEPTH);
            op_ready_s = strobe;
            opcode     = strobe ? WRITE : NOP;
            address    = 32'h2000 + 32'(sent * 16);
            lfsr       = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            deq_ready  = lfsr[0];
            check_count++; if (deq_valid !== (model > 0)) $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, deq_valid, model > 0); else pass_count++;
            if (model > 0 && deq_ready) begin
                check_count++; if (deq_address !== 32'h2000 + 32'(recv * 16)) $display("FAIL b2b_order idx=%0d got=%h exp=%h", recv, deq_address, 32'h2000 + 32'(recv * 16)); else pass_count++;
                recv++;
                model--;
            end
            if (strobe) begin
                sent++;
                model++;
            end
            tick();
        end
        op_ready_s = 1'b0;
        opcode     = NOP;
        deq_ready  = 1'b0;
        check_count++; if (recv != 20) $display("FAIL b2b_timeout got=%0d exp=20", recv); else pass_count++;
        check_count++; if (occupancy !== 5'd0) $display("FAIL b2b_final_occ got=%0d exp=0", occupancy); else pass_count++;
    endtask

    task automatic test_async_reset();
        do_reset();
        fill(32'h6000);
        push(READ, 32'h7000);
        #2 rst_n = 1'b0;
        #1;
        check_count++; if (queue_empty !== 1'b1 || queue_full !== 1'b0) $display("FAIL arst_status got empty=%b full=%b exp 1/0", queue_empty, queue_full); else pass_count++;
        check_count++; if (occupancy !== 5'd0 || deq_valid !== 1'b0) $display("FAIL arst_occ got occ=%0d valid=%b exp 0/0", occupancy, deq_valid); else pass_count++;
        check_count++; if (deq_opcode !== NOP || deq_address !== 32'h0) $display("FAIL arst_head got op=%0d addr=%h exp 0/0", deq_opcode, deq_address); else pass_count++;
        check_count++; if (overflow_err !== 1'b0) $display("FAIL arst_ovf got=%b exp=0", overflow_err); else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef REQ_AGE_EN
    task automatic test_age();
        do_reset();
        push(READ, 32'h5000);
        check_count++; if (deq_age !== 4'd0) $display("FAIL age_zero got=%0d exp=0", deq_age); else pass_count++;
        repeat (14) tick();
        check_count++; if (deq_age !== 4'd14) $display("FAIL age_14 got=%0d exp=14", deq_age); else pass_count++;
        repeat (6) tick();
        check_count++; if (deq_age !== 4'd15) $display("FAIL age_sat got=%0d exp=15", deq_age); else pass_count++;
        #2 rst_n = 1'b0;
        #1;
        check_count++; if (deq_age !== 4'd0) $display("FAIL age_arst got=%0d exp=0", deq_age); else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_strobe_deq();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
`ifdef REQ_AGE_EN
        test_age();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/request_queue.md
# request_queue

Bounded in-order request queue sitting between the trace parser and the DRAM command scheduler. It captures every op the parser presents with `op_ready_s`, holds up to `QUEUE_DEPTH` pending memory requests, and hands them to the scheduler over a valid/ready dequeue handshake. It reports occupancy and fullness upstream and flags requests dropped on overflow.

## Interface
Parameters:
- `QUEUE_DEPTH`, 16: number of request entries; must be a power of two, ≥2.
- `AGE_WIDTH`, 8: width of the per-entry age counter; only used with `REQ_AGE_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `op_ready_s`  in  1  one-cycle enqueue strobe from the parser.
- `opcode`  in  `parsed_op_t`  op to enqueue; sampled when `op_ready_s`=1.
- `address`  in  `ADDRESS_WIDTH`  address to enqueue; sampled with `opcode`.
- `queue_full`  out  1  count == `QUEUE_DEPTH`.
- `queue_empty`  out  1  count == 0.
- `occupancy`  out  $clog2(`QUEUE_DEPTH`)+1  current entry count.
- `deq_valid`  out  1  head entry present.
- `deq_ready`  in  1  scheduler accepts head this cycle.
- `deq_opcode`  out  `parsed_op_t`  head op; NOP when empty.
- `deq_address`  out  `ADDRESS_WIDTH`  head address; 0 when empty.
- `overflow_err`  out  1  sticky; set when an enqueue is dropped.
- `deq_age`  out  `AGE_WIDTH`  cycles the head has waited (only with `REQ_AGE_EN`).

## Operation
- Storage: circular buffer; write pointer, read pointer, count. Pointers are $clog2(`QUEUE_DEPTH`) bits and wrap naturally from `QUEUE_DEPTH`-1 to 0.
- Enqueue: occurs when `op_ready_s`=1, `opcode`≠NOP and count<`QUEUE_DEPTH`. Writes {opcode,address} at wptr, and wptr++.
- Strobe with `opcode`=NOP: ignored, with no state change.
- Dequeue: occurs when `deq_valid`&`deq_ready`. rptr++.
- Simultaneous enqueue+dequeue with 0<count<`QUEUE_DEPTH`: both happen and count is unchanged.
- Full with a strobe in the same cycle as a dequeue: the enqueue is rejected (full check uses pre-edge count), the entry is dropped, and `overflow_err` is set. Count becomes `QUEUE_DEPTH`-1.
- Empty with a strobe: the enqueue happens. There is no bypass, so `deq_valid` rises the next cycle.
- `deq_ready` while empty: ignored.
- `overflow_err` clears only on reset.
- Control FSM (for status only):
  - States: EMPTY, ACTIVE, FULL.
  - EMPTY→ACTIVE on enqueue.
  - ACTIVE→FULL when count reaches `QUEUE_DEPTH`.
  - ACTIVE→EMPTY when count reaches 0.
  - FULL→ACTIVE on dequeue.
  - `queue_full`/`queue_empty` decode from the state; they must agree with `occupancy`.

## Timing
- Reset (async assert, sync release), all outputs:
  - pointers and count = 0, state = EMPTY.
  - `queue_empty`=1, `queue_full`=0, `occupancy`=0.
  - `deq_valid`=0, `deq_opcode`=NOP, `deq_address`=0.
  - `overflow_err`=0, `deq_age`=0.
- Reset mid-operation: all contents are discarded immediately; there is no drain.
- Enqueue-to-`deq_valid` latency: 1 cycle.
- `deq_*` outputs are driven from registered head storage and are stable while `deq_valid`=1 and `deq_ready`=0.
- After a dequeue, the next head appears in the following cycle; back-to-back dequeues sustain 1/cycle.
- Status outputs reflect post-edge state.

## Configuration
- `REQ_AGE_EN` defined:
  - Each entry has an `AGE_WIDTH` counter, zeroed on enqueue.
  - The counter increments every cycle while the entry is resident and saturates at 2^`AGE_WIDTH`-1.
  - `deq_age` = the head entry's counter (0 when empty).
- `REQ_AGE_EN` undefined: no age storage; the `deq_age` port is absent.

## Structure
- `global_defs` package: `parsed_op_t` (already shared), `ADDRESS_WIDTH`, a new `queue_state_t` enum {EMPTY, ACTIVE, FULL}, and the `QUEUE_DEPTH` default constant.
- One natural sub-module: `queue_entry_ram`, holding the entry array plus the optional age counters. It has a write port and a read port indexed by pointer. The control module owns the pointers, count and FSM.

## Test plan
- Reset, then enqueue READ@0x1000 → one cycle later `deq_valid`=1, `deq_address`=0x1000, `occupancy`=1.
- Fill 16 entries with `deq_ready`=0 → `queue_full`=1. A 17th strobe sets `overflow_err`=1 and `occupancy` stays 16.
- Enqueue 20 and dequeue 20 with `deq_ready` toggling pseudo-randomly → output order matches input order and the pointers wrap past 15.
- At count=5, enqueue and dequeue in the same cycle → `occupancy` stays 5; head advances to the second entry.
- Full plus strobe plus dequeue in one cycle → strobe dropped, `overflow_err`=1, `occupancy`=15.
- `REQ_AGE_EN`, `AGE_WIDTH`=4: hold the head for 20 cycles → `deq_age` reads 15 (saturated). Assert `rst_n`=0 mid-run → all outputs return to reset values without waiting for a clock edge.
